rv_arch_state_unit: RTL and testbench
=====================================

Name: rv_arch_state_unit

Overview:
- Architectural state block of the single-cycle NPC core: general-purpose register file, program counter register, and a keyed write-back source selector with a default output.
- Sits between decode/execute and the next cycle.
- Supplies rs1/rs2 operands and the current PC.
- Commits one register write and the next PC on each rising clock edge.

Parameters:
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register, PC and data width.
- PC_RESET, 32'h8000_0000, PC value loaded by reset.

Ports:
- clk  input  1  single clock; all state updates occur on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rs1addr  input  ADDR_WIDTH  read port 1 index.
- rs2addr  input  ADDR_WIDTH  read port 2 index.
- rs1data  output  DATA_WIDTH  read port 1 data, combinational.
- rs2data  output  DATA_WIDTH  read port 2 data, combinational.
- waddr  input  ADDR_WIDTH  write index (rd).
- wen  input  1  register write enable.
- wb_key  input  3  write-back source select key.
- alu_res  input  DATA_WIDTH  write-back candidate: ALU result.
- mem_rdata  input  DATA_WIDTH  write-back candidate: load data.
- imm  input  DATA_WIDTH  write-back candidate: immediate (lui).
- wdata  output  DATA_WIDTH  selected write-back value, combinational.
- dnpc  input  DATA_WIDTH  dynamic next PC.
- pc_wen  input  1  PC update enable.
- pc  output  DATA_WIDTH  current PC, registered.
- snpc  output  DATA_WIDTH  static next PC, equal to pc+4, combinational.

Behaviour:
- Reset (rst=0), asynchronous and independent of clk:
  - pc <= PC_RESET.
  - All register entries <= 0.
  - Reset dominates wen and pc_wen.
  - Reset held across edges keeps this state.
  - Deassertion takes effect from the next rising edge.
- Register file, reads:
  - Two combinational read ports.
  - Index 0 always reads 0.
  - No write-to-read bypass: a read of the index being written returns the old value until the edge, then the new value.
- Register file, writes:
  - One synchronous write port.
  - On the rising edge with wen=1 and waddr!=0: entry[waddr] <= wdata.
  - Writes to index 0 are ignored.
  - wen=0 leaves all entries unchanged.
- Write-back mux (keyed, with default). wdata is selected by wb_key:
  - 3'b001 -> alu_res
  - 3'b010 -> mem_rdata
  - 3'b011 -> snpc
  - 3'b100 -> imm
  - Any other key (including 000, 101, 110, 111) -> 0 (default).
  - Keys are unique, so no priority is required.
  - Purely combinational; wdata is valid in the same cycle as its inputs.
- PC register:
  - On the rising edge with pc_wen=1: pc <= dnpc.
  - pc_wen=0 holds pc.
- snpc arithmetic:
  - snpc = pc + 4, modulo 2**DATA_WIDTH.
  - 32'hFFFF_FFFC wraps to 0.
- No alignment check on dnpc; any value is loaded as-is.
- Latency:
  - Register write and PC update are visible on the outputs one edge after the inputs are presented.
  - wdata and snpc have zero latency.
- Simultaneous register write and PC update in one cycle is legal and independent.
- Outputs contain no X after reset: all state is initialised by reset.

Test Plan:
- Reset: drive rst=0 mid-cycle with wen=1, pc_wen=1 -> pc=32'h8000_0000 immediately (no clock needed); rs1data=rs2data=0 for all indices; registers remain cleared while rst=0.
- Write/read: rst=1, wb_key=001, alu_res=32'hDEAD_BEEF, waddr=5, wen=1. Read rs1addr=5:
  - Before the edge, rs1data=0.
  - After one edge, rs1data=32'hDEAD_BEEF.
  - rs2addr=5 reads the same value.
- x0: wen=1, waddr=0, alu_res=32'h1234_5678, wb_key=001 -> after the edge, rs1addr=0 reads 0.
- wen=0 check: wen=0 on an edge leaves all entries unchanged.
- Mux sweep, with alu_res=1, mem_rdata=2, imm=3, pc=32'h8000_0000:
  - wb_key=001 -> wdata=1.
  - wb_key=010 -> wdata=2.
  - wb_key=011 -> wdata=32'h8000_0004.
  - wb_key=100 -> wdata=3.
  - wb_key=000, 101, 110, 111 -> wdata=0.
- PC: after reset, snpc=32'h8000_0004.
  - pc_wen=1, dnpc=snpc, 3 edges -> pc=32'h8000_000C.
  - pc_wen=0, 2 edges -> pc unchanged.
  - dnpc=32'hFFFF_FFFC, pc_wen=1, one edge -> pc=32'hFFFF_FFFC, snpc=0.
- Concurrent update: one edge with wen=1, waddr=31, wb_key=011 and pc_wen=1, dnpc=32'h8000_0100 -> x31 = old pc+4 and pc=32'h8000_0100.

Source files
------------

// File: rtl/rv_arch_state_if.sv
// Operand, write-back and PC bundle between the core datapath
// and the architectural state unit.
interface rv_arch_state_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rs1addr;
  logic [ADDR_WIDTH-1:0] rs2addr;
  logic [DATA_WIDTH-1:0] rs1data;
  logic [DATA_WIDTH-1:0] rs2data;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wen;
  logic [2:0]            wb_key;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] dnpc;
  logic                  pc_wen;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] snpc;

  modport master (
    output rs1addr, rs2addr, waddr, wen, wb_key,
    output alu_res, mem_rdata, imm, dnpc, pc_wen,
    input  rs1data, rs2data, wdata, pc, snpc
  );

  modport slave (
    input  rs1addr, rs2addr, waddr, wen, wb_key,
    input  alu_res, mem_rdata, imm, dnpc, pc_wen,
    output rs1data, rs2data, wdata, pc, snpc
  );
endinterface

// File: rtl/rv_arch_state_unit.sv
// Register file, PC register and write-back selector
// of the single-cycle core.
module rv_arch_state_unit #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h8000_0000
) (
  input logic             clk,
  input logic             rst,
  rv_arch_state_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [NREG];
  logic [DATA_WIDTH-1:0] rf_d [NREG];
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] snpc;
  logic [DATA_WIDTH-1:0] wdata;

  assign snpc = pc_q + DATA_WIDTH'(4);

  always_comb begin
    wdata = '0;
    unique case (1'b1)
      (bus.wb_key == 3'b001): wdata = bus.alu_res;
      (bus.wb_key == 3'b010): wdata = bus.mem_rdata;
      (bus.wb_key == 3'b011): wdata = snpc;
      (bus.wb_key == 3'b100): wdata = bus.imm;
      default:                wdata = '0;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    if (bus.wen && bus.waddr != '0) begin
      rf_d[bus.waddr] = wdata;
    end
    rf_d[0] = '0;
    pc_d = bus.pc_wen ? bus.dnpc : pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      pc_q <= PC_RESET;
    end else begin
      rf_q <= rf_d;
      pc_q <= pc_d;
    end
  end

  // x0 is gated at the read port as well as never written.
  assign bus.rs1data = (bus.rs1addr == '0) ? '0 : rf_q[bus.rs1addr];
  assign bus.rs2data = (bus.rs2addr == '0) ? '0 : rf_q[bus.rs2addr];
  assign bus.wdata   = wdata;
  assign bus.pc      = pc_q;
  assign bus.snpc    = snpc;
endmodule

// File: tb/tb_rv_arch_state_unit.sv
// Scoreboard bench: stimulus queues expected outputs, a
// negedge monitor pops and compares them.
module tb_rv_arch_state_unit;
  typedef enum int {
    S_RS1, S_RS2, S_WDATA, S_PC, S_SNPC
  } sel_e;

  typedef struct {
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic clk;
  logic rst;
  item_t sb_q[$];
  int total;
  int bad;

  rv_arch_state_if bus ();

  rv_arch_state_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input sel_e s, input logic [31:0] v,
                      input string n);
    item_t it;
    it.sel  = s;
    it.exp  = v;
    it.name = n;
    sb_q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      item_t it;
      logic [31:0] act;
      it = sb_q.pop_front();
      unique case (it.sel)
        S_RS1:   act = bus.rs1data;
        S_RS2:   act = bus.rs2data;
        S_WDATA: act = bus.wdata;
        S_PC:    act = bus.pc;
        default: act = bus.snpc;
      endcase
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h",
                 it.name, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] key_exp [8];
    key_exp = '{32'h0, 32'h1, 32'h2, 32'h8000_0004,
                32'h3, 32'h0, 32'h0, 32'h0};
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.rs1addr   = '0;
    bus.rs2addr   = '0;
    bus.waddr     = '0;
    bus.wen       = 1'b0;
    bus.wb_key    = 3'b000;
    bus.alu_res   = '0;
    bus.mem_rdata = '0;
    bus.imm       = '0;
    bus.dnpc      = '0;
    bus.pc_wen    = 1'b0;
    step();
    step();
    rst = 1'b1;

    // dirty some state so the later reset has work to do
    bus.wen     = 1'b1;
    bus.waddr   = 5'd7;
    bus.wb_key  = 3'b001;
    bus.alu_res = 32'hAAAA_5555;
    bus.pc_wen  = 1'b1;
    bus.dnpc    = 32'h1234_0000;
    step();
    bus.wen     = 1'b0;
    bus.pc_wen  = 1'b0;
    bus.rs1addr = 5'd7;
    push(S_RS1, 32'hAAAA_5555, "pre_rst_x7");
    push(S_PC, 32'h1234_0000, "pre_rst_pc");
    step();

    // async reset mid-cycle with writes requested
    rst         = 1'b0;
    bus.wen     = 1'b1;
    bus.pc_wen  = 1'b1;
    bus.alu_res = 32'hFFFF_FFFF;
    push(S_PC, 32'h8000_0000, "rst_pc_async");
    push(S_SNPC, 32'h8000_0004, "rst_snpc");
    push(S_RS1, 32'h0, "rst_x7_async");
    step();
    push(S_PC, 32'h8000_0000, "rst_pc_held");
    push(S_RS1, 32'h0, "rst_x7_held");
    step();
    for (int i = 0; i < 32; i++) begin
      bus.rs1addr = 5'(i);
      bus.rs2addr = 5'(31 - i);
      push(S_RS1, 32'h0, "rst_rs1_all");
      push(S_RS2, 32'h0, "rst_rs2_all");
      step();
    end
    rst        = 1'b1;
    bus.wen    = 1'b0;
    bus.pc_wen = 1'b0;
    step();

    // write then read, no bypass
    bus.wb_key  = 3'b001;
    bus.alu_res = 32'hDEAD_BEEF;
    bus.waddr   = 5'd5;
    bus.wen     = 1'b1;
    bus.rs1addr = 5'd5;
    bus.rs2addr = 5'd5;
    push(S_RS1, 32'h0, "wr_before_rs1");
    push(S_RS2, 32'h0, "wr_before_rs2");
    push(S_WDATA, 32'hDEAD_BEEF, "wr_wdata");
    step();
    bus.wen = 1'b0;
    push(S_RS1, 32'hDEAD_BEEF, "wr_after_rs1");
    push(S_RS2, 32'hDEAD_BEEF, "wr_after_rs2");
    step();

    // x0 write ignored
    bus.wen     = 1'b1;
    bus.waddr   = 5'd0;
    bus.alu_res = 32'h1234_5678;
    bus.rs1addr = 5'd0;
    step();
    bus.wen = 1'b0;
    push(S_RS1, 32'h0, "x0_read");
    step();

    // wen=0 leaves entries alone
    bus.waddr   = 5'd5;
    bus.alu_res = 32'h1111_1111;
    bus.rs1addr = 5'd5;
    step();
    push(S_RS1, 32'hDEAD_BEEF, "wen0_x5");
    step();

    // second entry, independent of x5
    bus.wen     = 1'b1;
    bus.waddr   = 5'd9;
    bus.alu_res = 32'h0000_0909;
    step();
    bus.wen     = 1'b0;
    bus.rs1addr = 5'd9;
    bus.rs2addr = 5'd5;
    push(S_RS1, 32'h0000_0909, "x9_read");
    push(S_RS2, 32'hDEAD_BEEF, "x5_kept");
    step();

    // write-back mux sweep with pc at reset value
    bus.alu_res   = 32'h1;
    bus.mem_rdata = 32'h2;
    bus.imm       = 32'h3;
    for (int k = 0; k < 8; k++) begin
      bus.wb_key = 3'(k);
      push(S_WDATA, key_exp[k], "mux_sweep");
      step();
    end

    // sequential PC advance
    push(S_SNPC, 32'h8000_0004, "pc_snpc_rst");
    bus.pc_wen = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      bus.dnpc = 32'h8000_0000 + 32'(4 * j);
      step();
    end
    bus.pc_wen = 1'b0;
    bus.dnpc   = 32'hDEAD_0000;
    push(S_PC, 32'h8000_000C, "pc_adv3");
    step();
    step();
    push(S_PC, 32'h8000_000C, "pc_hold");
    step();

    // wraparound of snpc
    bus.pc_wen = 1'b1;
    bus.dnpc   = 32'hFFFF_FFFC;
    step();
    bus.pc_wen = 1'b0;
    bus.wb_key = 3'b011;
    push(S_PC, 32'hFFFF_FFFC, "pc_top");
    push(S_SNPC, 32'h0, "snpc_wrap");
    push(S_WDATA, 32'h0, "wdata_snpc_wrap");
    step();

    // concurrent reg write and PC update
    bus.pc_wen = 1'b1;
    bus.dnpc   = 32'h8000_0040;
    step();
    bus.wen    = 1'b1;
    bus.waddr  = 5'd31;
    bus.wb_key = 3'b011;
    bus.dnpc   = 32'h8000_0100;
    push(S_WDATA, 32'h8000_0044, "conc_wdata");
    step();
    bus.wen     = 1'b0;
    bus.pc_wen  = 1'b0;
    bus.rs1addr = 5'd31;
    push(S_RS1, 32'h8000_0044, "conc_x31");
    push(S_PC, 32'h8000_0100, "conc_pc");
    push(S_SNPC, 32'h8000_0104, "conc_snpc");
    step();

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
      step();
    end
    if (sb_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
